// File: rtl/apb_gpio_pkg.sv
// Shared constants for the APB GPIO completer: register offsets, FSM states and wait-state limit.
package apb_gpio_pkg;

  localparam logic [4:0] OFS_DOUT     = 5'h00;
  localparam logic [4:0] OFS_DIR      = 5'h04;
  localparam logic [4:0] OFS_DIN      = 5'h08;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFS_IRQ_STAT = 5'h10;

  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned CNT_W           = $clog2(MAX_WAIT_STATES + 1);

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } state_e;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for the GPIO pad inputs, plus a previous-value flop for rising-edge detect.
module gpio_in_sync #(
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] din,
  output logic [GPIO_WIDTH-1:0] rise
);

  logic [GPIO_WIDTH-1:0] meta_q;
  logic [GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= gpio_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign din  = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/apb_gpio_completer.sv
// APB completer exposing a GPIO bank (DOUT, DIR, DIN, IRQ_EN, IRQ_STAT) with wait states and PSLVERR.
// Optional APB_GPIO_PPROT_CHECK_EN: unprivileged writes to DIR/IRQ_EN are rejected with PSLVERR.
module apb_gpio_completer
  import apb_gpio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STROBE_WIDTH = 4,
  parameter int unsigned GPIO_WIDTH   = 16,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [STROBE_WIDTH-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  output logic [GPIO_WIDTH-1:0]   gpio_oe,
  output logic                    irq
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [STROBE_WIDTH-1:0] strb_q, strb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic [GPIO_WIDTH-1:0]   dout_q, dout_d;
  logic [GPIO_WIDTH-1:0]   dir_q, dir_d;
  logic [GPIO_WIDTH-1:0]   ien_q, ien_d;
  logic [GPIO_WIDTH-1:0]   istat_q, istat_d;
  logic                    irq_q, irq_d;

  logic [GPIO_WIDTH-1:0]   din;
  logic [GPIO_WIDTH-1:0]   rise;
  logic                    setup;
  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic                    dec_write;
  logic [4:0]              off;
  logic                    addr_err;
  logic                    prot_err;
  logic                    acc_err;
  logic                    respond;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic [GPIO_WIDTH-1:0]   wmask;
  logic [GPIO_WIDTH-1:0]   wval;
  logic [GPIO_WIDTH-1:0]   w1c;
  logic                    unused_sig;

  gpio_in_sync #(
    .GPIO_WIDTH (GPIO_WIDTH)
  ) u_sync (
    .clk     (PCLK),
    .rst     (PRESET),
    .gpio_in (gpio_in),
    .din     (din),
    .rise    (rise)
  );

  assign setup = (state_q == IDLE) && PSEL && !PENABLE;

  // With zero wait states the response is computed at the setup edge, so decode the live bus there.
  assign dec_addr  = (state_q == IDLE) ? PADDR : addr_q;
  assign dec_write = (state_q == IDLE) ? PWRITE : write_q;
  assign off       = dec_addr[4:0];

  assign addr_err = (|dec_addr[1:0]) || (|dec_addr[ADDR_WIDTH-1:5]) || (off > OFS_IRQ_STAT);

`ifdef APB_GPIO_PPROT_CHECK_EN
  logic priv_q;
  logic dec_priv;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      priv_q <= 1'b0;
    end else if (setup) begin
      priv_q <= PPROT[0];
    end
  end

  assign dec_priv = (state_q == IDLE) ? PPROT[0] : priv_q;
  assign prot_err = dec_write && !dec_priv && ((off == OFS_DIR) || (off == OFS_IRQ_EN));
`else
  assign prot_err = 1'b0;
`endif

  assign acc_err    = addr_err || (dec_write && (off == OFS_DIN)) || prot_err;
  assign unused_sig = ^{PPROT, PWDATA, strb_q};

  always_comb begin
    rd_val = '0;
    case (off)
      OFS_DOUT:     rd_val[GPIO_WIDTH-1:0] = dout_q;
      OFS_DIR:      rd_val[GPIO_WIDTH-1:0] = dir_q;
      OFS_DIN:      rd_val[GPIO_WIDTH-1:0] = din;
      OFS_IRQ_EN:   rd_val[GPIO_WIDTH-1:0] = ien_q;
      OFS_IRQ_STAT: rd_val[GPIO_WIDTH-1:0] = istat_q;
      default:      ;
    endcase
  end

  // Transfer FSM and response generation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    respond   = 1'b0;
    commit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          strb_d  = PSTRB;
          cnt_d   = WAIT_INIT;
          state_d = ACCESS;
          respond = (WAIT_STATES == 0);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          if (PENABLE) begin
            commit    = write_q && !pslverr_q;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
          end
        end else if (cnt_q <= CNT_W'(1)) begin
          respond = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (respond) begin
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      if (!dec_write) begin
        prdata_d = acc_err ? '0 : rd_val;
      end
    end
  end

  // Register bank updates; commit only happens in ACCESS, where off reflects the latched address.
  always_comb begin
    for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
      wmask[i] = strb_q[i/8];
    end
    wval    = PWDATA[GPIO_WIDTH-1:0];
    dout_d  = dout_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    w1c     = '0;
    if (commit) begin
      case (off)
        OFS_DOUT:     dout_d = (dout_q & ~wmask) | (wval & wmask);
        OFS_DIR:      dir_d  = (dir_q & ~wmask) | (wval & wmask);
        OFS_IRQ_EN:   ien_d  = (ien_q & ~wmask) | (wval & wmask);
        OFS_IRQ_STAT: w1c    = wval & wmask;
        default:      ;
      endcase
    end
    // A new edge wins over a coincident clear.
    istat_d = (istat_q & ~w1c) | rise;
    irq_d   = |(istat_q & ien_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      dout_q    <= '0;
      dir_q     <= '0;
      ien_q     <= '0;
      istat_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      ien_q     <= ien_d;
      istat_q   <= istat_d;
      irq_q     <= irq_d;
    end
  end

  assign PRDATA   = prdata_q;
  assign PREADY   = pready_q;
  assign PSLVERR  = pslverr_q;
  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_gpio_completer.sv
// Bench for apb_gpio_completer: two instances (0 and 3 wait states) on a shared APB bus,
// with a response scoreboard of expected PRDATA/PSLVERR/wait counts.
module tb_apb_gpio_completer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel0, psel3, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [15:0] gpio_in;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [15:0] gout0, goe0, gout3, goe3;
  logic        irq0, irq3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  always #5 clk = ~clk;

  apb_gpio_completer #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .gpio_in(gpio_in), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0)
  );

  apb_gpio_completer #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .gpio_in(gpio_in), .gpio_out(gout3), .gpio_oe(goe3), .irq(irq3)
  );

  // Push the expected response, run one APB transfer, record what the DUT answered.
  task automatic xfer(input string name, input int t, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_w);
    exp_t e;
    obs_t o;
    int   w;
    e.name = name; e.rdata = exp_rd; e.err = exp_err; e.waits = exp_w;
    exp_q.push_back(e);
    psel0 = (t == 0); psel3 = (t == 3); penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge clk); #1;
    penable = 1'b1;
    w = 0;
    while (!((t == 0) ? pready0 : pready3) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    o.waits = w;
    o.err   = (t == 0) ? pslverr0 : pslverr3;
    o.rdata = wr ? 32'h0 : ((t == 0) ? prdata0 : prdata3);
    obs_q.push_back(o);
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001; gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b want=0", pready0); end
    checks++; if (pslverr0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b want=0", pslverr0); end
    checks++; if (prdata0 !== 32'h0) begin errors++; $display("FAIL reset_prdata got=%h want=0", prdata0); end
    checks++; if ({gout0, goe0, gout3, goe3} !== 64'h0) begin
      errors++; $display("FAIL reset_gpio got=%h/%h/%h/%h want=0", gout0, goe0, gout3, goe3);
    end
    checks++; if ({irq0, irq3, pready3} !== 3'b000) begin
      errors++; $display("FAIL reset_irq got=%b%b%b want=000", irq0, irq3, pready3);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    exp_t e; obs_t o;
    xfer("wr_dout", 0, 1, 32'h00, 32'h0000_A5A5, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    checks++; if (gout0 !== 16'hA5A5) begin errors++; $display("FAIL gpio_out got=%h want=a5a5", gout0); end
    xfer("rd_dout", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0000_A5A5, 1'b0, 0);
    xfer("wr_dir", 0, 1, 32'h04, 32'hFFFF_00FF, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    checks++; if (goe0 !== 16'h00FF) begin errors++; $display("FAIL gpio_oe got=%h want=00ff", goe0); end
    xfer("rd_dir", 0, 0, 32'h04, 32'h0, 4'h0, 3'b001, 32'h0000_00FF, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_wait_states;
    exp_t e; obs_t o;
    xfer("ws3_wr_dir", 3, 1, 32'h04, 32'h0000_0F0F, 4'hF, 3'b001, 32'h0, 1'b0, 3);
    xfer("ws3_rd_a", 3, 0, 32'h04, 32'h0, 4'h0, 3'b001, 32'h0000_0F0F, 1'b0, 3);
    xfer("ws3_rd_b2b", 3, 0, 32'h04, 32'h0, 4'h0, 3'b001, 32'h0000_0F0F, 1'b0, 3);
    xfer("ws3_err", 3, 0, 32'h14, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 3);
    checks++; if (goe3 !== 16'h0F0F) begin errors++; $display("FAIL ws3_oe got=%h want=0f0f", goe3); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_strobe;
    exp_t e; obs_t o;
    xfer("st_full", 0, 1, 32'h00, 32'h0000_1234, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    xfer("st_lane1", 0, 1, 32'h00, 32'h0000_FFFF, 4'h2, 3'b001, 32'h0, 1'b0, 0);
    xfer("st_rd1", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0000_FF34, 1'b0, 0);
    xfer("st_none", 0, 1, 32'h00, 32'h0000_0000, 4'h0, 3'b001, 32'h0, 1'b0, 0);
    xfer("st_upper", 0, 1, 32'h00, 32'hFFFF_0000, 4'hC, 3'b001, 32'h0, 1'b0, 0);
    xfer("st_rd2", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0000_FF34, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_errors;
    exp_t e; obs_t o;
    xfer("er_good", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0000_FF34, 1'b0, 0);
    xfer("er_rd14", 0, 0, 32'h14, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_rd02", 0, 0, 32'h02, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_wr08", 0, 1, 32'h08, 32'h0000_FFFF, 4'hF, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_hi", 0, 0, 32'h1000_0000, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_wr_alias", 0, 1, 32'h40, 32'h0000_0000, 4'hF, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_wr_mis", 0, 1, 32'h01, 32'h0000_0000, 4'hF, 3'b001, 32'h0, 1'b1, 0);
    xfer("er_rd_after", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0000_FF34, 1'b0, 0);
    checks++; if (gout0 !== 16'hFF34) begin errors++; $display("FAIL er_gpio got=%h want=ff34", gout0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_irq;
    exp_t e; obs_t o;
    xfer("irq_en", 0, 1, 32'h0C, 32'h0000_0001, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    gpio_in = 16'h0001;
    for (int i = 0; i < 4 && irq0 !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b want=1", irq0); end
    xfer("irq_stat", 0, 0, 32'h10, 32'h0, 4'h0, 3'b001, 32'h0000_0001, 1'b0, 0);
    xfer("irq_din", 0, 0, 32'h08, 32'h0, 4'h0, 3'b001, 32'h0000_0001, 1'b0, 0);
    xfer("irq_clr", 0, 1, 32'h10, 32'h0000_0001, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    @(posedge clk); #1;
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_cleared got=%b want=0", irq0); end
    gpio_in = 16'h0000;
    repeat (4) @(posedge clk);
    #1;
    // Raise the pin so the synchronised edge lands on the W1C completion edge.
    gpio_in = 16'h0001;
    @(posedge clk); #1;
    xfer("irq_coinc", 0, 1, 32'h10, 32'h0000_0001, 4'hF, 3'b001, 32'h0, 1'b0, 0);
    xfer("irq_stat2", 0, 0, 32'h10, 32'h0, 4'h0, 3'b001, 32'h0000_0001, 1'b0, 0);
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b want=1", irq0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

`ifdef APB_GPIO_PPROT_CHECK_EN
  task automatic test_pprot;
    exp_t e; obs_t o;
    xfer("pp_dir_user", 0, 1, 32'h04, 32'h0000_1111, 4'hF, 3'b000, 32'h0, 1'b1, 0);
    xfer("pp_dir_rd", 0, 0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0000_00FF, 1'b0, 0);
    xfer("pp_dout_user", 0, 1, 32'h00, 32'h0000_FF34, 4'hF, 3'b000, 32'h0, 1'b0, 0);
    checks++; if (goe0 !== 16'h00FF) begin errors++; $display("FAIL pp_oe got=%h want=00ff", goe0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    exp_t e; obs_t o;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h00; pwdata = 32'h0000_5555; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (gout0 !== 16'h0000) begin errors++; $display("FAIL rmid_dout got=%h want=0000", gout0); end
    checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL rmid_pready got=%b want=0", pready0); end
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer("rmid_rd", 0, 0, 32'h00, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, 0);
    checks++; if (gout0 !== 16'h0000) begin errors++; $display("FAIL rmid_dout2 got=%h want=0000", gout0); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.waits != e.waits) begin
        errors++;
        $display("FAIL %s got rdata=%h err=%b waits=%0d want rdata=%h err=%b waits=%0d",
                 e.name, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_strobe();
    test_errors();
    test_irq();
`ifdef APB_GPIO_PPROT_CHECK_EN
    test_pprot();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
